// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM states, default timing and row constants for keypad_scan
package keypad_pkg;
    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;
    localparam int SCAN_DIV_DEF = 50000;
    localparam int DEBOUNCE_CNT_DEF = 16;
    localparam logic [3:0] ROW_IDLE = 4'b1111;
    function automatic logic [1:0] low_row(input logic [3:0] rows);
        return !rows[0] ? 2'd0 : !rows[1] ? 2'd1 : !rows[2] ? 2'd2 : 2'd3;
    endfunction
endpackage

// File: rtl/keypad_scan_if.sv
// keypad_scan_if: keypad matrix lines and key event outputs of keypad_scan
interface keypad_scan_if;
    logic [3:0] ROW;
    logic [3:0] COL;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    modport master (input ROW, output COL, key_code, key_valid, key_held);
    modport slave (output ROW, input COL, key_code, key_valid, key_held);
endinterface

// File: rtl/tick_gen.sv
// tick_gen: free-running prescaler giving a one-cycle tick every DIV clocks
module tick_gen
    import keypad_pkg::*;
#(
    parameter int DIV = SCAN_DIV_DEF
) (
    input  logic CLK,
    input  logic RST,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] cnt;
    assign tick = cnt == W'(DIV - 1);
    always_ff @(posedge CLK)
        if (RST) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: debounced 4x4 matrix keypad scanner with column drive and key events
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEF,
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
    input logic CLK,
    input logic RST,
    keypad_scan_if.master kp
);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CNT - 1);
    logic          tick;
    logic [3:0]    rs1, rs;
    state_t        state, state_n;
    logic [1:0]    c, c_n, r, r_n;
    logic [CW-1:0] dcnt, dcnt_n, rcnt, rcnt_n;
    logic [3:0]    code_q, code_n;
    logic          valid_q, valid_n, held_q, held_n;
    tick_gen #(.DIV(SCAN_DIV)) u_tick (.CLK(CLK), .RST(RST), .tick(tick));
    assign kp.COL       = ~(4'b0001 << c);
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = held_q;
    always_ff @(posedge CLK) begin
        if (RST) begin
            rs1     <= ROW_IDLE;
            rs      <= ROW_IDLE;
            state   <= SCAN;
            c       <= '0;
            r       <= '0;
            dcnt    <= '0;
            rcnt    <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            rs1     <= kp.ROW;
            rs      <= rs1;
            state   <= state_n;
            c       <= c_n;
            r       <= r_n;
            dcnt    <= dcnt_n;
            rcnt    <= rcnt_n;
            code_q  <= code_n;
            valid_q <= valid_n;
            held_q  <= held_n;
        end
    end
    // Counters saturate so a very long press or release can never wrap back below CMAX.
    always_comb begin
        state_n = state;
        c_n     = c;
        r_n     = r;
        dcnt_n  = dcnt;
        rcnt_n  = rcnt;
        code_n  = code_q;
        valid_n = 1'b0;
        held_n  = held_q;
        if (tick)
            case (state)
                SCAN:
                    if (rs != ROW_IDLE) begin
                        r_n     = low_row(rs);
                        dcnt_n  = '0;
                        state_n = DEBOUNCE;
                    end else c_n = c + 2'd1;
                DEBOUNCE:
                    if (!rs[r]) begin
                        dcnt_n = dcnt == CMAX ? dcnt : dcnt + 1'b1;
                        if (dcnt_n == CMAX) begin
                            state_n = PRESSED;
                            code_n  = {r, c};
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                        end
                    end else begin
                        state_n = SCAN;
                        c_n     = c + 2'd1;
                    end
                PRESSED:
                    if (rs == ROW_IDLE) begin
                        state_n = RELEASE;
                        rcnt_n  = '0;
                    end
                RELEASE:
                    if (rs == ROW_IDLE) begin
                        rcnt_n = rcnt == CMAX ? rcnt : rcnt + 1'b1;
                        if (rcnt_n == CMAX) begin
                            held_n  = 1'b0;
                            state_n = SCAN;
                            c_n     = c + 2'd1;
                        end
                    end else state_n = PRESSED;
                default: state_n = SCAN;
            endcase
    end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: keypad matrix model driving keypad_scan with a scoreboard of accepted key codes
module tb_keypad_scan;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic [15:0] pressed = '0;
    logic [3:0] row_v;
    int tests = 0;
    int fails = 0;
    int got_n = 0;
    int rd = 0;
    int cons_n = 0;
    logic prev_valid = 1'b0;
    logic [3:0] got_code [0:63];
    logic [3:0] exp_q [$];

    keypad_scan_if kif ();
    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (.CLK(CLK), .RST(RST), .kp(kif));

    always #5 CLK = ~CLK;

    // Matrix model: a pressed key (index 4*row+col) pulls its row low while its column is driven low.
    always_comb begin
        row_v = 4'b1111;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (pressed[4*rr+cc] && !kif.COL[cc]) row_v[rr] = 1'b0;
    end
    assign kif.ROW = row_v;

    always @(negedge CLK) begin
        if (kif.key_valid && got_n < 64) begin
            got_code[got_n] = kif.key_code;
            got_n++;
        end
        if (kif.key_valid && prev_valid) cons_n++;
        prev_valid = kif.key_valid;
    end

    task automatic wait_col_entry(input logic [3:0] col, output bit ok);
        int n = 0;
        while (kif.COL == col && n < 40) begin @(negedge CLK); n++; end
        while (kif.COL != col && n < 80) begin @(negedge CLK); n++; end
        ok = kif.COL == col;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        pressed = '0;
        repeat (3) @(negedge CLK);
        tests++; if (kif.COL !== 4'b1110) begin fails++; $display("FAIL reset_col: COL=%b required 1110", kif.COL); end
        tests++; if (kif.key_code !== 4'd0) begin fails++; $display("FAIL reset_code: key_code=%0d required 0", kif.key_code); end
        tests++; if (kif.key_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: key_valid=%b required 0", kif.key_valid); end
        tests++; if (kif.key_held !== 1'b0) begin fails++; $display("FAIL reset_held: key_held=%b required 0", kif.key_held); end
        RST = 1'b0;
        @(negedge CLK);
        tests++; if (kif.COL !== 4'b1110) begin fails++; $display("FAIL reset_col_after: COL=%b required 1110", kif.COL); end
    endtask

    task automatic test_idle();
        logic [3:0] prev;
        logic [3:0] e;
        int changes = 0;
        int bad = 0;
        prev = kif.COL;
        repeat (40) begin
            @(negedge CLK);
            if (!(kif.COL inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) bad++;
            if (kif.COL != prev) begin
                changes++;
                if (kif.COL != {prev[2:0], prev[3]}) bad++;
            end
            prev = kif.COL;
        end
        tests++; if (changes != 10) begin fails++; $display("FAIL idle_rate: %0d column steps in 40 cycles, required 10", changes); end
        tests++; if (bad != 0) begin fails++; $display("FAIL idle_order: %0d bad column values, required 0", bad); end
        while (rd < got_n) begin
            tests++;
            if (exp_q.size() == 0) begin fails++; $display("FAIL idle_sb: got key_valid code %0d, required no pulse", got_code[rd]); end
            else begin e = exp_q.pop_front(); if (got_code[rd] !== e) begin fails++; $display("FAIL idle_sb: key_code %0d, required %0d", got_code[rd], e); end end
            rd++;
        end
    endtask

    task automatic test_press_hold();
        logic [3:0] e;
        int n = 0;
        pressed[9] = 1'b1;
        exp_q.push_back(4'd9);
        do begin @(negedge CLK); n++; end while (!kif.key_valid && n < 120);
        tests++; if (kif.key_valid !== 1'b1) begin fails++; $display("FAIL press_valid: no key_valid in %0d cycles, required a pulse", n); end
        tests++; if (kif.key_held !== 1'b1) begin fails++; $display("FAIL press_held: key_held=%b at pulse, required 1", kif.key_held); end
        repeat (20) @(negedge CLK);
        tests++; if (kif.COL !== 4'b1101) begin fails++; $display("FAIL press_col: COL=%b while held, required 1101", kif.COL); end
        pressed = '0;
        repeat (6) @(negedge CLK);
        tests++; if (kif.key_held !== 1'b1) begin fails++; $display("FAIL press_held_rel: key_held=%b early in release, required 1", kif.key_held); end
        repeat (14) @(negedge CLK);
        tests++; if (kif.key_held !== 1'b0) begin fails++; $display("FAIL press_unheld: key_held=%b after release, required 0", kif.key_held); end
        while (rd < got_n) begin
            tests++;
            if (exp_q.size() == 0) begin fails++; $display("FAIL press_sb: got key_valid code %0d, required no pulse", got_code[rd]); end
            else begin e = exp_q.pop_front(); if (got_code[rd] !== e) begin fails++; $display("FAIL press_sb: key_code %0d, required %0d", got_code[rd], e); end end
            rd++;
        end
        tests++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL press_sb: %0d pulse(s) missing, first code %0d", exp_q.size(), exp_q[0]); exp_q.delete(); end
    endtask

    task automatic test_glitch();
        logic [3:0] e;
        bit ok;
        wait_col_entry(4'b0111, ok);
        tests++; if (!ok) begin fails++; $display("FAIL glitch_col_wait: COL=%b, required to reach 0111", kif.COL); end
        pressed[3] = 1'b1;
        repeat (8) @(negedge CLK);
        pressed = '0;
        repeat (6) @(negedge CLK);
        tests++; if (kif.COL !== 4'b1110) begin fails++; $display("FAIL glitch_resume: COL=%b, required 1110", kif.COL); end
        tests++; if (kif.key_held !== 1'b0) begin fails++; $display("FAIL glitch_held: key_held=%b, required 0", kif.key_held); end
        repeat (20) @(negedge CLK);
        while (rd < got_n) begin
            tests++;
            if (exp_q.size() == 0) begin fails++; $display("FAIL glitch_sb: got key_valid code %0d, required no pulse", got_code[rd]); end
            else begin e = exp_q.pop_front(); if (got_code[rd] !== e) begin fails++; $display("FAIL glitch_sb: key_code %0d, required %0d", got_code[rd], e); end end
            rd++;
        end
    endtask

    task automatic test_multi_row();
        logic [3:0] e;
        int n = 0;
        pressed[4] = 1'b1;
        pressed[12] = 1'b1;
        exp_q.push_back(4'd4);
        do begin @(negedge CLK); n++; end while (!kif.key_valid && n < 120);
        tests++; if (kif.key_valid !== 1'b1) begin fails++; $display("FAIL multi_valid: no key_valid in %0d cycles, required a pulse", n); end
        repeat (10) @(negedge CLK);
        pressed = '0;
        repeat (25) @(negedge CLK);
        tests++; if (kif.key_held !== 1'b0) begin fails++; $display("FAIL multi_unheld: key_held=%b, required 0", kif.key_held); end
        while (rd < got_n) begin
            tests++;
            if (exp_q.size() == 0) begin fails++; $display("FAIL multi_sb: got key_valid code %0d, required no pulse", got_code[rd]); end
            else begin e = exp_q.pop_front(); if (got_code[rd] !== e) begin fails++; $display("FAIL multi_sb: key_code %0d, required %0d", got_code[rd], e); end end
            rd++;
        end
        tests++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL multi_sb: %0d pulse(s) missing, first code %0d", exp_q.size(), exp_q[0]); exp_q.delete(); end
    endtask

    task automatic test_release_bounce();
        logic [3:0] e;
        int n = 0;
        int drops = 0;
        pressed[2] = 1'b1;
        exp_q.push_back(4'd2);
        do begin @(negedge CLK); n++; end while (!kif.key_valid && n < 120);
        tests++; if (kif.key_valid !== 1'b1) begin fails++; $display("FAIL bounce_valid: no key_valid in %0d cycles, required a pulse", n); end
        repeat (10) @(negedge CLK);
        pressed = '0;
        repeat (5) @(negedge CLK);
        pressed[2] = 1'b1;
        repeat (20) begin
            @(negedge CLK);
            if (kif.key_held !== 1'b1) drops++;
        end
        tests++; if (drops != 0) begin fails++; $display("FAIL bounce_held: key_held low for %0d cycles, required 0", drops); end
        pressed = '0;
        repeat (25) @(negedge CLK);
        tests++; if (kif.key_held !== 1'b0) begin fails++; $display("FAIL bounce_unheld: key_held=%b, required 0", kif.key_held); end
        while (rd < got_n) begin
            tests++;
            if (exp_q.size() == 0) begin fails++; $display("FAIL bounce_sb: got key_valid code %0d, required no pulse", got_code[rd]); end
            else begin e = exp_q.pop_front(); if (got_code[rd] !== e) begin fails++; $display("FAIL bounce_sb: key_code %0d, required %0d", got_code[rd], e); end end
            rd++;
        end
        tests++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL bounce_sb: %0d pulse(s) missing, first code %0d", exp_q.size(), exp_q[0]); exp_q.delete(); end
    endtask

    task automatic test_reset_abort();
        logic [3:0] e;
        int n = 0;
        bit ok;
        wait_col_entry(4'b1101, ok);
        tests++; if (!ok) begin fails++; $display("FAIL abort_col_wait: COL=%b, required to reach 1101", kif.COL); end
        pressed[13] = 1'b1;
        repeat (6) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        tests++; if (kif.COL !== 4'b1110) begin fails++; $display("FAIL abort_col: COL=%b, required 1110", kif.COL); end
        tests++; if (kif.key_code !== 4'd0) begin fails++; $display("FAIL abort_code: key_code=%0d, required 0", kif.key_code); end
        tests++; if (kif.key_valid !== 1'b0 || kif.key_held !== 1'b0) begin fails++; $display("FAIL abort_flags: valid=%b held=%b, required 0 0", kif.key_valid, kif.key_held); end
        RST = 1'b0;
        exp_q.push_back(4'd13);
        do begin @(negedge CLK); n++; end while (!kif.key_valid && n < 120);
        tests++; if (kif.key_valid !== 1'b1) begin fails++; $display("FAIL abort_redetect: no key_valid in %0d cycles, required a pulse", n); end
        repeat (10) @(negedge CLK);
        pressed = '0;
        repeat (25) @(negedge CLK);
        tests++; if (kif.key_held !== 1'b0) begin fails++; $display("FAIL abort_unheld: key_held=%b, required 0", kif.key_held); end
        while (rd < got_n) begin
            tests++;
            if (exp_q.size() == 0) begin fails++; $display("FAIL abort_sb: got key_valid code %0d, required no pulse", got_code[rd]); end
            else begin e = exp_q.pop_front(); if (got_code[rd] !== e) begin fails++; $display("FAIL abort_sb: key_code %0d, required %0d", got_code[rd], e); end end
            rd++;
        end
        tests++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL abort_sb: %0d pulse(s) missing, first code %0d", exp_q.size(), exp_q[0]); exp_q.delete(); end
        tests++; if (cons_n != 0) begin fails++; $display("FAIL valid_width: %0d back-to-back key_valid cycles, required 0", cons_n); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_press_hold();
        test_glitch();
        test_multi_row();
        test_release_bounce();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
